// File: rtl/bm_mem_pkg.sv
// Shared sizing, column type and write-FSM state encoding for the bitmatrix column store.
package bm_mem_pkg;

    localparam int unsigned W             = 8;
    localparam int unsigned K_MAX         = 8;
    localparam int unsigned M_MAX         = 4;
    localparam int unsigned BM_COL_W      = W * W * K_MAX;
    localparam int unsigned BM_MEM_ADDR_W = $clog2(M_MAX);
    localparam int unsigned HOST_W        = 32;

    typedef logic [BM_COL_W-1:0] bm_col_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCommit
    } bm_mem_wr_state_e;

endpackage

// File: rtl/bm_col_assembler.sv
// Collects HOST_W-bit host beats into one bitmatrix column and presents it for a
// single-cycle commit into the column array.
module bm_col_assembler #(
    parameter int unsigned BM_COL_W = bm_mem_pkg::BM_COL_W,
    parameter int unsigned HOST_W   = bm_mem_pkg::HOST_W,
    parameter int unsigned ADDR_W   = bm_mem_pkg::BM_MEM_ADDR_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    input  logic                wr_val,
    input  logic [HOST_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   wr_col,
    output logic                wr_rdy,
    output logic                commit,
    output logic [ADDR_W-1:0]   commit_addr,
    output logic [BM_COL_W-1:0] commit_col
);
    import bm_mem_pkg::*;

    localparam int unsigned BEATS = BM_COL_W / HOST_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);

    bm_mem_wr_state_e    state_q, state_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [BM_COL_W-1:0] assy_q, assy_d;
    logic [ADDR_W-1:0]   col_addr_q, col_addr_d;
    logic                accept;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        assy_d     = assy_q;
        col_addr_d = col_addr_q;
        // clr forces rdy low so a beat arriving with it is dropped, not half-taken
        wr_rdy     = rstn && !clr && (state_q != StCommit);
        accept     = wr_val && wr_rdy;

        if (clr) begin
            state_d    = StIdle;
            beat_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        assy_d[0 +: HOST_W] = wr_data;
                        col_addr_d          = wr_col;
                        beat_cnt_d          = CNT_W'(1);
                        state_d             = StLoad;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        assy_d[beat_cnt_q * HOST_W +: HOST_W] = wr_data;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        if (beat_cnt_q == LastBeat) begin
                            state_d = StCommit;
                        end
                    end
                end
                StCommit: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Datapath registers carry no reset; only the control state must be defined.
    always_ff @(posedge clk) begin
        assy_q     <= assy_d;
        col_addr_q <= col_addr_d;
    end

    // The array write happens even if clr lands in the commit cycle.
    assign commit      = (state_q == StCommit);
    assign commit_addr = col_addr_q;
    assign commit_col  = assy_q;

endmodule

// File: rtl/bm_mem.sv
// Bitmatrix column store: host-side column assembly and commit, controller-side
// single-column reads with fixed one-cycle latency and read-before-write ordering.
module bm_mem #(
    parameter int unsigned W             = bm_mem_pkg::W,
    parameter int unsigned K_MAX         = bm_mem_pkg::K_MAX,
    parameter int unsigned M_MAX         = bm_mem_pkg::M_MAX,
    parameter int unsigned BM_COL_W      = W * W * K_MAX,
    parameter int unsigned BM_MEM_ADDR_W = $clog2(M_MAX),
    parameter int unsigned HOST_W        = bm_mem_pkg::HOST_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     host_bm_mem_clr,
    input  logic                     host_bm_mem_wr_val,
    input  logic [HOST_W-1:0]        host_bm_mem_wr_data,
    input  logic [BM_MEM_ADDR_W-1:0] host_bm_mem_wr_col,
    output logic                     bm_mem_host_wr_rdy,
    output logic [M_MAX-1:0]         bm_mem_col_vld,
    output logic                     bm_mem_rd_err,
    input  logic                     bm_cntl_bm_mem_rd_rq,
    input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
    output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
    output logic                     bm_mem_bm_cntl_rd_data_val
);
    import bm_mem_pkg::*;

    logic                     commit;
    logic [BM_MEM_ADDR_W-1:0] commit_addr;
    logic [BM_COL_W-1:0]      commit_col;

    logic [BM_COL_W-1:0]      mem [M_MAX];
    logic [M_MAX-1:0]         col_vld_q, col_vld_d;
    logic                     rd_err_q, rd_err_d;
    logic [BM_COL_W-1:0]      rd_data_q;
    logic                     rd_val_q;

    bm_col_assembler #(
        .BM_COL_W (BM_COL_W),
        .HOST_W   (HOST_W),
        .ADDR_W   (BM_MEM_ADDR_W)
    ) u_assembler (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (host_bm_mem_clr),
        .wr_val      (host_bm_mem_wr_val),
        .wr_data     (host_bm_mem_wr_data),
        .wr_col      (host_bm_mem_wr_col),
        .wr_rdy      (bm_mem_host_wr_rdy),
        .commit      (commit),
        .commit_addr (commit_addr),
        .commit_col  (commit_col)
    );

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[commit_addr] <= commit_col;
        end
    end

    always_comb begin
        col_vld_d = col_vld_q;
        rd_err_d  = rd_err_q;
        if (host_bm_mem_clr) begin
            col_vld_d = '0;
            rd_err_d  = 1'b0;
        end else begin
            if (commit) begin
                col_vld_d[commit_addr] = 1'b1;
            end
            if (bm_cntl_bm_mem_rd_rq && !col_vld_q[bm_cntl_bm_mem_rd_addr]) begin
                rd_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_vld_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            col_vld_q <= col_vld_d;
            rd_err_q  <= rd_err_d;
        end
    end

    // Sampling mem before the same-edge commit lands gives read-before-write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
            rd_val_q  <= 1'b0;
        end else begin
            rd_val_q <= bm_cntl_bm_mem_rd_rq;
            if (bm_cntl_bm_mem_rd_rq) begin
                rd_data_q <= mem[bm_cntl_bm_mem_rd_addr];
            end
        end
    end

    assign bm_mem_col_vld             = col_vld_q;
    assign bm_mem_rd_err              = rd_err_q;
    assign bm_mem_bm_cntl_rd_data     = rd_data_q;
    assign bm_mem_bm_cntl_rd_data_val = rd_val_q;

endmodule

// File: tb/tb_bm_mem.sv
// Self-checking bench for bm_mem: directed scenarios plus randomized traffic
// compared against a column-array reference model.
module tb_bm_mem;
    import bm_mem_pkg::*;

    localparam int unsigned BEATS = BM_COL_W / HOST_W;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b1;
    logic                     clr = 1'b0;
    logic                     wr_val = 1'b0;
    logic [HOST_W-1:0]        wr_data = '0;
    logic [BM_MEM_ADDR_W-1:0] wr_col = '0;
    logic                     wr_rdy;
    logic [M_MAX-1:0]         col_vld;
    logic                     rd_err;
    logic                     rd_rq = 1'b0;
    logic [BM_MEM_ADDR_W-1:0] rd_addr = '0;
    bm_col_t                  rd_data;
    logic                     rd_val;

    bm_col_t          ref_mem [M_MAX];
    logic [M_MAX-1:0] ref_vld = '0;
    logic [M_MAX-1:0] ref_known = '0;
    logic             ref_err = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bm_mem dut (
        .clk                        (clk),
        .rstn                       (rstn),
        .host_bm_mem_clr            (clr),
        .host_bm_mem_wr_val         (wr_val),
        .host_bm_mem_wr_data        (wr_data),
        .host_bm_mem_wr_col         (wr_col),
        .bm_mem_host_wr_rdy         (wr_rdy),
        .bm_mem_col_vld             (col_vld),
        .bm_mem_rd_err              (rd_err),
        .bm_cntl_bm_mem_rd_rq       (rd_rq),
        .bm_cntl_bm_mem_rd_addr     (rd_addr),
        .bm_mem_bm_cntl_rd_data     (rd_data),
        .bm_mem_bm_cntl_rd_data_val (rd_val)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bm_col_t rand_col();
        bm_col_t c;
        for (int n = 0; n < BEATS; n++) c[n*HOST_W +: HOST_W] = HOST_W'($urandom());
        return c;
    endfunction

    // Streams a full column; returns in the commit cycle. mid_col < 0 randomizes wr_col after beat 0.
    task automatic send_beats(input int addr, input bm_col_t col, input bit gaps, input int mid_col);
        for (int n = 0; n < BEATS; n++) begin
            wr_val  = 1'b1;
            wr_data = col[n*HOST_W +: HOST_W];
            if (n == 0) wr_col = BM_MEM_ADDR_W'(addr);
            else if (mid_col >= 0) wr_col = BM_MEM_ADDR_W'(mid_col);
            else wr_col = BM_MEM_ADDR_W'($urandom_range(0, M_MAX - 1));
            #1;
            if (wr_rdy !== 1'b1) begin
                n_err++; $display("FAIL beat_rdy: beat %0d got %b expected 1", n, wr_rdy);
            end
            n_vec++;
            step();
            wr_val = 1'b0;
            if (gaps && n < BEATS - 1) repeat ($urandom_range(1, 3)) step();
        end
        if (wr_rdy !== 1'b0) begin
            n_err++; $display("FAIL commit_rdy: got %b expected 0", wr_rdy);
        end
        n_vec++;
    endtask

    task automatic finish_commit(input int addr, input bm_col_t col);
        step();
        ref_mem[addr]   = col;
        ref_known[addr] = 1'b1;
        ref_vld[addr]   = 1'b1;
        if (wr_rdy !== 1'b1) begin
            n_err++; $display("FAIL post_commit_rdy: got %b expected 1", wr_rdy);
        end
        n_vec++;
        if (col_vld !== ref_vld) begin
            n_err++; $display("FAIL col_vld: got %b expected %b", col_vld, ref_vld);
        end
        n_vec++;
    endtask

    task automatic do_read(input int addr);
        rd_rq   = 1'b1;
        rd_addr = BM_MEM_ADDR_W'(addr);
        if (!ref_vld[addr]) ref_err = 1'b1;
        step();
        rd_rq = 1'b0;
        if (rd_val !== 1'b1) begin
            n_err++; $display("FAIL rd_val: addr %0d got %b expected 1", addr, rd_val);
        end
        n_vec++;
        if (ref_known[addr]) begin
            if (rd_data !== ref_mem[addr]) begin
                n_err++; $display("FAIL rd_data: addr %0d got %h expected %h", addr, rd_data, ref_mem[addr]);
            end
            n_vec++;
        end
        if (rd_err !== ref_err) begin
            n_err++; $display("FAIL rd_err: got %b expected %b", rd_err, ref_err);
        end
        n_vec++;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        ref_vld = '0;
        ref_err = 1'b0;
        if (col_vld !== '0 || rd_err !== 1'b0) begin
            n_err++; $display("FAIL clr_state: got vld %b err %b expected 0 0", col_vld, rd_err);
        end
        n_vec++;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #2;
        if ({wr_rdy, col_vld, rd_err, rd_val} !== '0) begin
            n_err++; $display("FAIL reset_ctrl: got rdy %b vld %b err %b val %b expected 0", wr_rdy, col_vld, rd_err, rd_val);
        end
        n_vec++;
        if (rd_data !== '0) begin
            n_err++; $display("FAIL reset_data: got %h expected 0", rd_data);
        end
        n_vec++;
        #9 rstn = 1'b1;
        step();
        if (wr_rdy !== 1'b1) begin
            n_err++; $display("FAIL idle_rdy: got %b expected 1", wr_rdy);
        end
        n_vec++;
    endtask

    task automatic test_load_col2();
        bm_col_t c;
        for (int n = 0; n < BEATS; n++) c[n*HOST_W +: HOST_W] = HOST_W'(n);
        send_beats(2, c, 1'b0, -1);
        finish_commit(2, c);
        if (col_vld !== 4'b0100) begin
            n_err++; $display("FAIL col2_vld: got %b expected 0100", col_vld);
        end
        n_vec++;
        do_read(2);
    endtask

    task automatic test_gapped();
        bm_col_t c = rand_col();
        send_beats(1, c, 1'b1, 3);
        finish_commit(1, c);
        do_read(1);
    endtask

    task automatic test_collision();
        bm_col_t a = rand_col();
        bm_col_t b = rand_col();
        send_beats(0, a, 1'b0, -1);
        finish_commit(0, a);
        send_beats(0, b, 1'b0, -1);
        rd_rq   = 1'b1;
        rd_addr = '0;
        step();
        rd_rq = 1'b0;
        if (rd_val !== 1'b1 || rd_data !== a) begin
            n_err++; $display("FAIL collision_old: got val %b data %h expected 1 %h", rd_val, rd_data, a);
        end
        n_vec++;
        ref_mem[0] = b;
        do_read(0);
    endtask

    task automatic test_back_to_back();
        bm_col_t c = rand_col();
        send_beats(3, c, 1'b0, -1);
        finish_commit(3, c);
        for (int a = 0; a < M_MAX; a++) begin
            rd_rq   = 1'b1;
            rd_addr = BM_MEM_ADDR_W'(a);
            step();
            if (rd_val !== 1'b1 || rd_data !== ref_mem[a]) begin
                n_err++; $display("FAIL b2b: addr %0d got val %b data %h expected 1 %h", a, rd_val, rd_data, ref_mem[a]);
            end
            n_vec++;
        end
        rd_rq = 1'b0;
        step();
        if (rd_val !== 1'b0 || rd_data !== ref_mem[M_MAX-1]) begin
            n_err++; $display("FAIL rd_hold: got val %b data %h expected 0 %h", rd_val, rd_data, ref_mem[M_MAX-1]);
        end
        n_vec++;
    endtask

    task automatic test_clr_during_load();
        bm_col_t c = rand_col();
        for (int n = 0; n < 7; n++) begin
            wr_val  = 1'b1;
            wr_data = c[n*HOST_W +: HOST_W];
            wr_col  = BM_MEM_ADDR_W'(1);
            step();
        end
        wr_data = c[7*HOST_W +: HOST_W];
        clr     = 1'b1;
        #1;
        if (wr_rdy !== 1'b0) begin
            n_err++; $display("FAIL clr_rdy: got %b expected 0", wr_rdy);
        end
        n_vec++;
        step();
        clr     = 1'b0;
        wr_val  = 1'b0;
        ref_vld = '0;
        ref_err = 1'b0;
        if (col_vld !== '0 || rd_err !== 1'b0) begin
            n_err++; $display("FAIL clr_load: got vld %b err %b expected 0 0", col_vld, rd_err);
        end
        n_vec++;
        c = rand_col();
        send_beats(1, c, 1'b0, -1);
        finish_commit(1, c);
        do_read(1);
    endtask

    task automatic test_unwritten();
        bm_col_t c = rand_col();
        pulse_clr();
        do_read(3);
        send_beats(2, c, 1'b0, -1);
        finish_commit(2, c);
        do_read(2);
        pulse_clr();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int op = int'($urandom_range(0, 9));
            int a  = int'($urandom_range(0, M_MAX - 1));
            if (op <= 3) begin
                bm_col_t c = rand_col();
                send_beats(a, c, 1'($urandom_range(0, 1)), -1);
                finish_commit(a, c);
            end else if (op <= 7) begin
                do_read(a);
            end else if (op == 8) begin
                repeat ($urandom_range(2, 4)) do_read(int'($urandom_range(0, M_MAX - 1)));
            end else begin
                pulse_clr();
            end
        end
    endtask

    task automatic test_async_reset();
        bm_col_t c = rand_col();
        pulse_clr();
        send_beats(0, c, 1'b0, -1);
        finish_commit(0, c);
        c = rand_col();
        for (int n = 0; n < 5; n++) begin
            wr_val  = 1'b1;
            wr_data = c[n*HOST_W +: HOST_W];
            wr_col  = BM_MEM_ADDR_W'(2);
            if (n == 4) begin
                rd_rq   = 1'b1;
                rd_addr = BM_MEM_ADDR_W'(3);
            end
            step();
        end
        wr_val = 1'b0;
        rd_rq  = 1'b0;
        if (rd_err !== 1'b1 || rd_val !== 1'b1) begin
            n_err++; $display("FAIL pre_reset: got err %b val %b expected 1 1", rd_err, rd_val);
        end
        n_vec++;
        #2 rstn = 1'b0;
        #1;
        if ({wr_rdy, col_vld, rd_err, rd_val} !== '0 || rd_data !== '0) begin
            n_err++; $display("FAIL async_reset: got rdy %b vld %b err %b val %b data %h expected all 0",
                              wr_rdy, col_vld, rd_err, rd_val, rd_data);
        end
        n_vec++;
        ref_vld = '0;
        ref_err = 1'b0;
        #3 rstn = 1'b1;
        step();
        c = rand_col();
        send_beats(2, c, 1'b0, -1);
        finish_commit(2, c);
        do_read(2);
    endtask

    initial begin
        test_reset();
        test_load_col2();
        test_gapped();
        test_collision();
        test_back_to_back();
        test_clr_during_load();
        test_unwritten();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bm_mem.md
Name: bm_mem

Overview:
- Bitmatrix column store sitting directly upstream of the bitmatrix memory controller.
- Host/config side streams each bitmatrix column in HOST_W-bit beats. Beats are assembled into one BM_COL_W-bit column, then committed to an M_MAX-entry array.
- Controller side issues single-column read requests. Each is answered one cycle later with the full column and a valid strobe.

Parameters:
- W, 8, Galois-field word width (bits)
- K_MAX, 8, max data chunks
- M_MAX, 4, max parity chunks = number of stored columns
- BM_COL_W, W*W*K_MAX (512), bits per bitmatrix column
- BM_MEM_ADDR_W, 2, clog2(M_MAX)
- HOST_W, 32, host beat width; BM_COL_W must be a multiple of HOST_W
- BEATS, BM_COL_W/HOST_W (16), beats per column (local, not overridable)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- host_bm_mem_clr  in  1  pulse: clear column-valid mask, abort any assembly in progress
- host_bm_mem_wr_val  in  1  beat valid
- host_bm_mem_wr_data  in  HOST_W  beat payload
- host_bm_mem_wr_col  in  BM_MEM_ADDR_W  target column; sampled on first beat only
- bm_mem_host_wr_rdy  out  1  beat accepted when val&rdy
- bm_mem_col_vld  out  M_MAX  per-column "written since clr" mask
- bm_mem_rd_err  out  1  sticky: read hit an unwritten column; cleared by clr
- bm_cntl_bm_mem_rd_rq  in  1  read request
- bm_cntl_bm_mem_rd_addr  in  BM_MEM_ADDR_W  column to read
- bm_mem_bm_cntl_rd_data  out  BM_COL_W  column data
- bm_mem_bm_cntl_rd_data_val  out  1  one-cycle strobe qualifying rd_data

Behaviour:
- Reset state (rstn low, async): FSM=IDLE, beat_cnt=0, wr_rdy=0 while in reset, col_vld=0, rd_err=0, rd_data=0, rd_data_val=0. The storage array is not reset.
- Write FSM has three states:
  - IDLE: wr_rdy=1. An accepted beat stores data into assy[HOST_W-1:0], latches col_addr, sets beat_cnt=1, goes to LOAD.
  - LOAD: wr_rdy=1. Beat n writes assy[n*HOST_W +: HOST_W] and increments beat_cnt. The beat with beat_cnt==BEATS-1 moves the FSM to COMMIT and wraps beat_cnt to 0. wr_col is ignored in LOAD.
  - COMMIT: wr_rdy=0 for exactly 1 cycle. Writes mem[col_addr]<=assy, sets col_vld[col_addr], then returns to IDLE. Column accept-to-commit throughput is BEATS+1 cycles.
- Gaps in wr_val are allowed. Assembly holds state indefinitely.
- host_bm_mem_clr takes priority over everything in the write path:
  - col_vld<=0 and rd_err<=0.
  - From LOAD, FSM goes to IDLE, beat_cnt<=0, and the partial column is discarded.
  - A clr in COMMIT does not block the array write, but col_vld stays 0.
  - A beat presented in the same cycle as clr is dropped, because wr_rdy is forced to 0 that cycle.
- Read path has fixed latency 1:
  - rd_rq at edge t gives rd_data=mem[rd_addr] and rd_data_val=1 at t+1.
  - No rd_rq gives rd_data_val=0 the next cycle; rd_data holds its last value.
  - Back-to-back requests return data every cycle.
  - Reads are never stalled by the write FSM.
- Read/write same cycle, same address: read returns the OLD contents (read-before-write). The next read sees the new contents.
- Read of a column with col_vld==0: data returned as stored (X after power-up), val still asserted, rd_err set (sticky).
- Width rules: beat index n maps to bits [n*HOST_W +: HOST_W], LSB beat first. Counters are clog2(BEATS) bits and wrap naturally.

Decomposition:
- Shared package (global_parameters):
  - W, K_MAX, M_MAX, BM_COL_W, BM_MEM_ADDR_W, HOST_W.
  - typedef bm_col_t = logic [BM_COL_W-1:0].
  - enum bm_mem_wr_state_e {IDLE, LOAD, COMMIT}.
- One natural sub-module, bm_col_assembler: holds the FSM, beat counter and assembly register, and outputs a commit strobe, address and column. The array and read port stay in bm_mem.

Test Plan:
- Load column 2:
  - Stimulus: 16 beats 32'h0000_0000+n, contiguous.
  - Response: wr_rdy drops 1 cycle after beat 15 and col_vld=4'b0100.
  - Then read addr 2: rd_data_val at +1 and rd_data[n*32 +: 32]==n for all n.
- Gapped load: beats with wr_val low between each, and wr_col changed to 3 mid-column. Column still lands in the first-beat address; other col_vld bits unchanged.
- Clr during load: after 7 beats to column 1, pulse clr together with beat 8. Beat dropped, FSM goes to IDLE, and col_vld=0. Then a fresh 16-beat load commits correctly.
- Read/write collision: column 0 holds A. Commit B to column 0 while rd_rq addr 0 in the COMMIT cycle. Returned data==A; the next-cycle read returns B.
- Back-to-back reads of addrs 0,1,2,3 on 4 consecutive cycles: val high 4 consecutive cycles, data in order.
- Unwritten read and reset:
  - After clr, read column 3: val=1 and rd_err=1 sticky until the next clr.
  - Assert rstn low mid-LOAD: all outputs return to reset values asynchronously.
